// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and request check for the load/store unit
// Contents:
//   F3_*          funct3 encodings for loads/stores
//   lsu_state_t   FSM state encoding
//   lsu_req_bad   1 when a request is illegal or misaligned
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // READ_MOD is kept as a named encoding; the read half of a sub-word
  // store happens in the accept cycle, so the FSM never visits it.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ_MOD = 2'd1,
    WRITE    = 2'd2,
    RESP     = 2'd3
  } lsu_state_t;

  function automatic logic lsu_req_bad(input logic       write,
                                       input logic [2:0] f3,
                                       input logic [1:0] offset);
    logic illegal;
    logic misaligned;
    // Stores only have b/h/w forms, so any funct3 with bit 2 set is illegal for them.
    illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (write && f3[2]);
    misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && offset[0]) ||
                 ((f3 == F3_W) && (offset != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane extract/extend for loads and lane merge for stores
// Ports:
//   word      in   32  memory word (load source, or old word for a merge)
//   offset    in   2   byte offset within the word (addr[1:0])
//   funct3    in   3   access size / signedness
//   new_data  in   32  store data; low byte/halfword used for sub-word stores
//   load_val  out  32  extracted and sign/zero-extended load value
//   merged    out  32  word with the addressed lane replaced by new_data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] new_data,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Little-endian: byte lane n is bits [8n+7:8n], halfword lane is picked by offset[1].
  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_val = 32'd0;
    case (funct3)
      F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_val = {24'd0, lane_b};
      F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_val = {16'd0, lane_h};
      F3_W:    load_val = word;
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B:    merged[{offset, 3'b000} +: 8]      = new_data[7:0];
      F3_H:    merged[{offset[1], 4'b0000} +: 16] = new_data[15:0];
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sub-word load/store unit between control stage and word-wide data memory
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_write  request present / 1 = store
//   funct3, addr, wdata  access type, byte address, store data
//   stall                hold pipeline until the op completes
//   done, err, rdata     completion pulse, error flag, extended load result
//   mem_A/WE/WD/RD       word-aligned data memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [2:0]               funct3,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     stall,
  output logic                     done,
  output logic                     err,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic                     mem_WE,
  output logic [DATA_WIDTH-1:0]    mem_WD,
  input  logic [DATA_WIDTH-1:0]    mem_RD
);

  lsu_state_t               state;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [2:0]               funct3_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    merge_buf;

  logic                     in_idle;
  logic                     accept;
  logic                     bad;
  logic                     sw_now;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]    align_word;
  logic [2:0]               align_f3;
  logic [DATA_WIDTH-1:0]    load_val;
  logic [DATA_WIDTH-1:0]    merged;

  // In IDLE the live request drives the memory port and aligner; afterwards
  // the captured request does, so the core may change its inputs freely.
  always_comb begin
    in_idle    = (state == IDLE);
    accept     = in_idle && req_valid;
    bad        = lsu_req_bad(req_write, funct3, addr[1:0]);
    sw_now     = accept && req_write && (funct3 == F3_W) && !bad;
    cur_addr   = in_idle ? addr : addr_q;
    align_word = in_idle ? mem_RD : merge_buf;
    align_f3   = in_idle ? funct3 : funct3_q;
    mem_A      = {cur_addr[ADDRESS_WIDTH-1:2], 2'b00};
    mem_WE     = !rst && (sw_now || (state == WRITE));
    mem_WD     = (state == WRITE) ? merged : wdata;
    stall      = (state != RESP) && (!in_idle || req_valid);
  end

  lsu_align u_align (
    .word     (align_word),
    .offset   (cur_addr[1:0]),
    .funct3   (align_f3),
    .new_data (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // done/err are registered: they are set on the transition into RESP and
  // cleared on every other cycle, so they pulse exactly while in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= F3_B;
      write_q   <= 1'b0;
      merge_buf <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
            write_q  <= req_write;
            if (bad) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
              if (!req_write) rdata <= '0;
            end else if (!req_write) begin
              rdata <= load_val;
              state <= RESP;
              done  <= 1'b1;
            end else if (funct3 == F3_W) begin
              state <= RESP;
              done  <= 1'b1;
            end else begin
              merge_buf <= mem_RD;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          state <= RESP;
          done  <= 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sub-word load/store unit between the ALU/control stage and the word-wide data memory of the reduced RISC-V core. It takes a memory request (ALU address, rs2 data, funct3) and produces the word-aligned memory access. Byte and halfword stores are done as read-modify-write, and load results are sign- or zero-extended before they go to the ResultSrc writeback mux. The core is held on `stall` until the unit pulses `done`.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data/word width; fixed at 32 (4 byte lanes)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  memory instruction present this cycle
- req_write  in  1  1 = store, 0 = load
- funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000/001/010 (stores)
- addr  in  ADDRESS_WIDTH  byte address (ALU result)
- wdata  in  DATA_WIDTH  store data (rs2)
- stall  out  1  hold PC/pipeline
- done  out  1  one-cycle pulse: op complete, rdata/err valid
- err  out  1  with done: misaligned or illegal funct3
- rdata  out  DATA_WIDTH  extended load result, registered
- mem_A  out  ADDRESS_WIDTH  word address, addr[1:0] forced 00
- mem_WE  out  1  memory write enable
- mem_WD  out  DATA_WIDTH  memory write word
- mem_RD  in  DATA_WIDTH  memory read word (combinational read, synchronous write)

## Operation
- FSM states: IDLE, READ_MOD, WRITE, RESP.
- IDLE with req_valid: capture addr, wdata, funct3, req_write into request registers.
  - Illegal or misaligned request -> RESP with err set; no memory write ever issued.
  - lw/lh/lhu/lb/lbu: read the word this cycle, extract the lane, extend it, register it into rdata -> RESP.
  - sw: mem_WE=1, mem_WD=wdata this cycle -> RESP.
  - sb/sh: read the word this cycle, capture mem_RD into merge buffer -> WRITE.
- WRITE: mem_WE=1; mem_WD = buffer with the byte/halfword lane replaced by wdata_q[7:0]/[15:0] -> RESP.
- RESP: done=1, stall=0 -> IDLE. req_valid in RESP is ignored (same instruction).
- Illegal funct3: 011, 110, 111, or a store with funct3[2]=1.
- Misaligned: h/hu with addr[0]=1; w with addr[1:0]!=0.
- Lane select: byte = addr[1:0]; halfword = addr[1]. Little-endian.
- Sign extension from bit 7/15 for b/h; zero extension for bu/hu.
- rdata holds its last value until the next load completes. Stores and errors leave rdata unchanged, except an errored load, which writes 0.
- err is valid only with done, and 0 otherwise.

## Timing
- stall = (state != RESP) && (state != IDLE || req_valid). It is combinational, high from the accept cycle until RESP.
- Latency from accept to done:
  - load: 1 cycle
  - sw: 1 cycle
  - sb/sh: 2 cycles
  - error: 1 cycle
- mem_A is driven from live addr in IDLE and from the captured address in all other states.
- mem_WE = ~rst && (IDLE-accepted sw, or WRITE). Reset during WRITE suppresses the write.
- Reset values: state IDLE, done 0, err 0, rdata 0, mem_WE 0, stall follows req_valid. mem_WD and mem_A are don't-care when mem_WE=0.
- Reset mid-operation aborts the op with no partial write and no done pulse.
- Back-to-back requests: the earliest next accept is the cycle after RESP.

## Structure
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum lsu_state_t
- Sub-module lsu_align is purely combinational and provides:
  - load extract/extend from (word, offset, funct3)
  - store merge from (old word, new data, offset, funct3)
- The top holds the FSM, the request registers and the merge buffer.

## Test plan
- Memory word 0x8000_00F0 at 0x10. lb 0x10 -> done 1 cycle later, rdata 0xFFFF_FFF0. lbu 0x10 -> rdata 0x0000_00F0. lh 0x12 -> rdata 0xFFFF_8000.
- Memory 0x1122_3344 at 0x20. sb 0x21, wdata 0xAB -> 2-cycle latency, exactly one mem_WE pulse; memory becomes 0x1122_AB44.
- sh 0x22, wdata 0xBEEF on 0x1122_3344 -> 0xBEEF_3344. sw 0x24, wdata 0xDEAD_BEEF -> single-cycle write, done next cycle.
- lw 0x21, sh 0x23, and funct3=011 -> err=1 with done, mem_WE never 1, rdata 0 for the load cases.
- rst asserted in the WRITE cycle of sb -> mem_WE stays 0, memory unchanged, no done, state IDLE next cycle.
- Back-to-back: lw then sb with req_valid held -> second accept in the cycle after the first RESP, with no lost or duplicated done.
